// File: rtl/mskaes_128bits_host_ctrl.sv
// rtl/mskaes_128bits_host_ctrl.sv - host-side initiator for the masked round-based AES-128 core
//
// Collects an unmasked key and plaintext as 32-bit words and splits each into
// d shares with fresh randomness. It then issues one encryption to the masked
// core, recombines the shared ciphertext and streams it back as 32-bit words.
// It also reports how many cycles the core took.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data      host words: 4 key then 4 plaintext, MSW first
//   out_valid/out_ready/out_data   ciphertext words, MSW first
//   rnd_share                      fresh masks: key slices low half, plaintext slices high half
//   lat_cycles                     issue-to-cipher_valid cycles of the last encryption
//   core_valid_in/core_ready       issue handshake towards the core
//   core_cipher_valid              core completion strobe
//   core_sh_key/core_sh_plaintext  share-major sharings (share j at [128*j +: 128])
//   core_sh_ciphertext             share-major shared ciphertext from the core

module mskaes_128bits_host_ctrl #(
   parameter int d     = 2,
   parameter int LAT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   input  logic [256*(d-1)-1:0]   rnd_share,
   output logic [LAT_W-1:0]       lat_cycles,
   output logic                   core_valid_in,
   input  logic                   core_ready,
   input  logic                   core_cipher_valid,
   output logic [128*d-1:0]       core_sh_plaintext,
   output logic [128*d-1:0]       core_sh_key,
   input  logic [128*d-1:0]       core_sh_ciphertext
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHARE,
      S_ISSUE,
      S_BUSY,
      S_OUT
   } state_t;

   state_t             state_q;
   logic [2:0]         cnt_q;
   logic [127:0]       key_q;
   logic [127:0]       pt_q;
   logic [127:0]       ct_q;
   logic [128*d-1:0]   sh_key_q;
   logic [128*d-1:0]   sh_pt_q;
   logic [LAT_W-1:0]   lat_cnt_q;
   logic [LAT_W-1:0]   lat_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               core_valid_q;

   logic [128*d-1:0]   sh_key_d;
   logic [128*d-1:0]   sh_pt_d;
   logic [127:0]       ct_d;
   logic [LAT_W-1:0]   lat_d;
   logic [6:0]         word_lsb;

   // Word 0 of each 128-bit block is the most significant one.
   assign word_lsb = {~cnt_q[1:0], 5'd0};

   // Shares 1..d-1 are the raw mask slices; share 0 absorbs the value so the
   // XOR of all shares equals the unmasked data.
   always_comb begin
      sh_key_d        = '0;
      sh_pt_d         = '0;
      sh_key_d[127:0] = key_q;
      sh_pt_d[127:0]  = pt_q;
      for (int j = 1; j < d; j++) begin
         sh_key_d[128*j +: 128] = rnd_share[128*(j-1) +: 128];
         sh_pt_d[128*j +: 128]  = rnd_share[128*(d+j-2) +: 128];
         sh_key_d[127:0]        = sh_key_d[127:0] ^ rnd_share[128*(j-1) +: 128];
         sh_pt_d[127:0]         = sh_pt_d[127:0] ^ rnd_share[128*(d+j-2) +: 128];
      end
   end

   always_comb begin
      ct_d = '0;
      for (int j = 0; j < d; j++) begin
         ct_d = ct_d ^ core_sh_ciphertext[128*j +: 128];
      end
   end

   assign lat_d = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         key_q        <= '0;
         pt_q         <= '0;
         ct_q         <= '0;
         sh_key_q     <= '0;
         sh_pt_q      <= '0;
         lat_cnt_q    <= '0;
         lat_q        <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         core_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  if (cnt_q[2]) pt_q[word_lsb +: 32]  <= in_data;
                  else          key_q[word_lsb +: 32] <= in_data;
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_q    <= S_SHARE;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            S_SHARE: begin
               // Masks are sampled here only; the plain copies are wiped.
               sh_key_q     <= sh_key_d;
               sh_pt_q      <= sh_pt_d;
               key_q        <= '0;
               pt_q         <= '0;
               core_valid_q <= 1'b1;
               state_q      <= S_ISSUE;
            end
            S_ISSUE: begin
               if (core_ready) begin
                  // Drop the sharings once the core owns them.
                  sh_key_q     <= '0;
                  sh_pt_q      <= '0;
                  core_valid_q <= 1'b0;
                  lat_cnt_q    <= '0;
                  state_q      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (core_cipher_valid) begin
                  ct_q        <= ct_d;
                  lat_q       <= lat_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_OUT;
               end else begin
                  lat_cnt_q <= lat_d;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd3) begin
                     cnt_q       <= '0;
                     ct_q        <= '0;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = out_valid_q;
   assign out_data          = ct_q[word_lsb +: 32];
   assign lat_cycles        = lat_q;
   assign core_valid_in     = core_valid_q;
   assign core_sh_key       = sh_key_q;
   assign core_sh_plaintext = sh_pt_q;

endmodule
